// File: rtl/load_store_unit_if.sv
// Purpose: request/response and data-memory signals of the load/store unit.
// Latency: none, wires only.
// Backpressure: req_ready carries the unit's stall back to the MEM stage.
//
// Signals:
//   req_valid/req_ready      request handshake
//   req_store/size/unsigned  operation, access size (00 b, 01 h, 10 w, 11 d), load extension
//   req_addr/req_wdata       byte address, right-aligned store data
//   resp_valid/rdata/err     one-cycle response pulse with load data / error flag
//   mem_adr/datain/w/r       dword-aligned memory address, write data, strobes
//   mem_dataout              combinational read data from memory
//
// Modports: slave is the unit itself; master is its environment (pipeline MEM stage
// together with the data memory, which supplies mem_dataout).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_adr;
    logic [63:0] mem_datain;
    logic        mem_w;
    logic        mem_r;
    logic [63:0] mem_dataout;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dataout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_adr, mem_datain, mem_w, mem_r
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dataout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_adr, mem_datain, mem_w, mem_r
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding load/store initiator for the 64-bit byte-addressed data memory.
// Latency: accept->resp_valid: load 2, dword store 2, sub-dword store 3 (read-merge-write), error 1.
// Backpressure: req_ready is high only in IDLE; the MEM stage holds its request until accepted.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; aborts any access in flight without a response
//   lsu    load_store_unit_if.slave: request/response handshake and data-memory port
//
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned or out-of-range requests
// with resp_err. Without it no checks are made, resp_err is 0, and lanes that run past
// the dword boundary are truncated (store bytes dropped, load bytes read as 0).
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   lsu
);

    if ((MEM_BYTES % 8) != 0 || MEM_BYTES == 0) begin : g_bad_mem_bytes
        $error("load_store_unit: MEM_BYTES must be a nonzero multiple of 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    state_t      state_q, state_d;

    // Request fields captured at the accept edge
    logic        store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [2:0]  lane_q;
    logic [63:0] base_q;
    logic [63:0] wdata_q;
    logic        err_q;
    // Memory dword captured at the end of RD
    logic [63:0] rbuf_q;

    logic        accept;
    logic        req_err;

    assign accept = lsu.req_valid && (state_q == S_IDLE);

    // ------------------------------------------------------------------
    // Request checking
    // ------------------------------------------------------------------
`ifdef LSU_ALIGN_CHECK_EN
    logic misaligned;
    logic out_of_range;

    // The lane must be a multiple of the access size.
    always_comb begin
        misaligned = 1'b0;
        case (lsu.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lsu.req_addr[0];
            2'b10:   misaligned = |lsu.req_addr[1:0];
            default: misaligned = |lsu.req_addr[2:0];
        endcase
    end

    assign out_of_range = {lsu.req_addr[63:3], 3'b000} >= 64'(MEM_BYTES);
    assign req_err      = misaligned | out_of_range;
`else
    assign req_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Store merge: the store data is shifted up to its lane and replaces
    // the selected bytes of the dword read back during RD. Bytes that would
    // land past lane 7 fall off the top of both the data and the byte mask.
    // ------------------------------------------------------------------
    logic [7:0]  size_mask;
    logic [7:0]  byte_mask;
    logic [63:0] wdata_shifted;
    logic [63:0] merged;
    logic [63:0] wbuf;

    always_comb begin
        case (size_q)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign byte_mask     = size_mask << lane_q;
    assign wdata_shifted = wdata_q << {lane_q, 3'b000};

    always_comb begin
        merged = rbuf_q;
        for (int i = 0; i < 8; i++) begin
            if (byte_mask[i]) begin
                merged[8*i +: 8] = wdata_shifted[8*i +: 8];
            end
        end
    end

    // A dword store skips the read, so the merge source is not valid there.
    assign wbuf = (size_q == 2'b11) ? wdata_q : merged;

    // ------------------------------------------------------------------
    // Load extraction: shift the lane down (zero fill past byte 7), keep
    // the access width, then sign- or zero-extend.
    // ------------------------------------------------------------------
    logic [63:0] rbuf_shifted;
    logic        ext_neg;
    logic [63:0] load_val;

    assign rbuf_shifted = rbuf_q >> {lane_q, 3'b000};

    always_comb begin
        ext_neg  = 1'b0;
        load_val = rbuf_shifted;
        case (size_q)
            2'b00: begin
                ext_neg  = ~unsigned_q & rbuf_shifted[7];
                load_val = {{56{ext_neg}}, rbuf_shifted[7:0]};
            end
            2'b01: begin
                ext_neg  = ~unsigned_q & rbuf_shifted[15];
                load_val = {{48{ext_neg}}, rbuf_shifted[15:0]};
            end
            2'b10: begin
                ext_neg  = ~unsigned_q & rbuf_shifted[31];
                load_val = {{32{ext_neg}}, rbuf_shifted[31:0]};
            end
            default: begin
                ext_neg  = 1'b0;
                load_val = rbuf_shifted;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            lane_q     <= 3'd0;
            base_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rbuf_q     <= '0;
        end else begin
            if (accept) begin
                store_q    <= lsu.req_store;
                size_q     <= lsu.req_size;
                unsigned_q <= lsu.req_unsigned;
                lane_q     <= lsu.req_addr[2:0];
                base_q     <= {lsu.req_addr[63:3], 3'b000};
                wdata_q    <= lsu.req_wdata;
                err_q      <= req_err;
            end
            if (state_q == S_RD) begin
                rbuf_q <= lsu.mem_dataout;
            end
        end
    end

    // mem_adr follows the captured base, so it holds between accesses.
    assign lsu.mem_adr = base_q;

    // ------------------------------------------------------------------
    // Next state and outputs. Outputs depend on state and captured fields
    // only; req_* feed nothing but the next-state choice in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        lsu.req_ready  = 1'b0;
        lsu.mem_r      = 1'b0;
        lsu.mem_w      = 1'b0;
        lsu.mem_datain = '0;
        lsu.resp_valid = 1'b0;
        lsu.resp_rdata = '0;
        lsu.resp_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                lsu.req_ready = 1'b1;
                if (lsu.req_valid) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (lsu.req_store && (lsu.req_size == 2'b11)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                lsu.mem_r = 1'b1;
                state_d   = store_q ? S_WR : S_RESP;
            end
            S_WR: begin
                lsu.mem_w      = 1'b1;
                lsu.mem_datain = wbuf;
                state_d        = S_RESP;
            end
            S_RESP: begin
                lsu.resp_valid = 1'b1;
                lsu.resp_rdata = (store_q || err_q) ? 64'd0 : load_val;
`ifdef LSU_ALIGN_CHECK_EN
                lsu.resp_err   = err_q;
`endif
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array reference memory predicts every response,
// strobe cycle and write dword; a negedge process compares the DUT against it each cycle,
// and directed operations pin the model with literal expectations.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if lif();

    load_store_unit #(.MEM_BYTES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (lif)
    );

    // Data memory seen by the DUT: 4 dwords, combinational read, write at rising edge.
    logic [63:0] dmem [0:3];
    assign lif.mem_dataout = lif.mem_r ? dmem[lif.mem_adr[4:3]] : 64'hDEAD_0BAD_DEAD_0BAD;
    always @(posedge clk) if (lif.mem_w) dmem[lif.mem_adr[4:3]] <= lif.mem_datain;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    typedef struct {
        int          cyc;
        int          acc;
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t        expq[$];
    logic [7:0]  ref_mem [0:31];
    int          cur_acc  = -10;
    int          cur_rd   = -10;
    int          cur_wr   = -10;
    int          cur_resp = -10;
    logic [63:0] exp_base = '0;
    logic [63:0] exp_wr   = '0;
    bit          free_strobes = 1'b0;
    bit          run_chk      = 1'b0;
    bit          exp_v;

    // Observations for literal checks
    logic [63:0] last_rdata  = '0;
    logic [63:0] last_wdat   = '0;
    logic [63:0] last_rd_adr = '0;
    int          last_lat    = 0;
    int          n_rd = 0, n_wr = 0, n_resp = 0;
    int          resp_cyc[$];
    logic [63:0] resp_dat[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endfunction

    // Predict one accepted request. acc is cycle 0 (the cycle that ends with the accept edge).
    task automatic model_accept(input bit st, input logic [1:0] sz, input bit un,
                                input logic [63:0] a, input logic [63:0] wd, input int acc);
        int          nb, lane, b, resp;
        logic [63:0] base, v;
        bit          err;
        exp_t        e;
        nb   = 1 << sz;
        lane = int'(a[2:0]);
        base = {a[63:3], 3'b000};
        err  = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        err = ((lane % nb) != 0) || (base >= 64'd32);
`endif
        b        = int'(base[4:0]);
        v        = '0;
        cur_acc  = acc;
        cur_rd   = -10;
        cur_wr   = -10;
        exp_base = base;
        if (err) begin
            resp = acc + 1;
        end else if (!st) begin
            for (int k = 0; k < nb; k++)
                if (lane + k < 8) v[8*k +: 8] = ref_mem[b + lane + k];
            if (!un && nb < 8 && v[8*nb - 1]) v = v | (~64'd0 << (8*nb));
            cur_rd = acc + 1;
            resp   = acc + 2;
        end else begin
            if (sz == 2'b11) begin
                for (int k = 0; k < 8; k++) ref_mem[b + k] = wd[8*k +: 8];
                cur_wr = acc + 1;
                resp   = acc + 2;
            end else begin
                for (int k = 0; k < nb; k++)
                    if (lane + k < 8) ref_mem[b + lane + k] = wd[8*k +: 8];
                cur_rd = acc + 1;
                cur_wr = acc + 2;
                resp   = acc + 3;
            end
            for (int k = 0; k < 8; k++) exp_wr[8*k +: 8] = ref_mem[b + k];
        end
        cur_resp = resp;
        e.cyc    = resp;
        e.acc    = acc;
        e.rdata  = (err || st) ? 64'd0 : v;
        e.err    = err;
        expq.push_back(e);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (lif.mem_r) begin n_rd++; last_rd_adr = lif.mem_adr; end
        if (lif.mem_w) begin n_wr++; last_wdat = lif.mem_datain; end
        if (lif.resp_valid) begin
            n_resp++;
            resp_cyc.push_back(cyc);
            resp_dat.push_back(lif.resp_rdata);
        end
        if (run_chk && !reset) begin
            exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
            chk1("resp_valid", lif.resp_valid, exp_v);
            if (exp_v) begin
                if (lif.resp_valid) begin
                    chk("resp_rdata", lif.resp_rdata, expq[0].rdata);
                    chk1("resp_err", lif.resp_err, expq[0].err);
                    last_rdata = lif.resp_rdata;
                    last_lat   = cyc - expq[0].acc;
                end
                void'(expq.pop_front());
            end
            chk1("rw_exclusive", lif.mem_r & lif.mem_w, 1'b0);
            if (!free_strobes) begin
                chk1("mem_r", lif.mem_r, cyc == cur_rd);
                chk1("mem_w", lif.mem_w, cyc == cur_wr);
                chk1("req_ready", lif.req_ready, !(cyc > cur_acc && cyc <= cur_resp));
                if (lif.mem_r || lif.mem_w) chk("mem_adr", lif.mem_adr, exp_base);
                chk("mem_datain", lif.mem_datain, (cyc == cur_wr) ? exp_wr : 64'd0);
            end else begin
                chk1("mem_w_abort", lif.mem_w, 1'b0);
                chk("mem_datain_abort", lif.mem_datain, 64'd0);
            end
        end
    end

    task automatic issue(input bit st, input logic [1:0] sz, input bit un,
                         input logic [63:0] a, input logic [63:0] wd, input bit track);
        int n;
        n = 0;
        lif.req_store    = st;
        lif.req_size     = sz;
        lif.req_unsigned = un;
        lif.req_addr     = a;
        lif.req_wdata    = wd;
        lif.req_valid    = 1'b1;
        @(negedge clk);
        while (!lif.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("accept_wait", lif.req_ready, 1'b1);
        @(posedge clk);
        #1;
        if (track) model_accept(st, sz, un, a, wd, cyc - 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() > 0 || cyc <= cur_resp) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(expq.size()), 64'd0);
    endtask

    task automatic do_op(input bit st, input logic [1:0] sz, input bit un,
                         input logic [63:0] a, input logic [63:0] wd);
        issue(st, sz, un, a, wd, 1'b1);
        lif.req_valid = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] saved;
        int          r0, w0, p0;
        reset            = 1'b1;
        lif.req_valid    = 1'b0;
        lif.req_store    = 1'b0;
        lif.req_size     = 2'b00;
        lif.req_unsigned = 1'b0;
        lif.req_addr     = '0;
        lif.req_wdata    = '0;
        for (int i = 0; i < 4; i++) begin
            dmem[i] = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
            for (int k = 0; k < 8; k++) ref_mem[8*i + k] = 8'(8*i + k);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_req_ready", lif.req_ready, 1'b1);
        chk1("rst_resp_valid", lif.resp_valid, 1'b0);
        chk1("rst_resp_err", lif.resp_err, 1'b0);
        chk("rst_resp_rdata", lif.resp_rdata, 64'd0);
        chk1("rst_mem_w", lif.mem_w, 1'b0);
        chk1("rst_mem_r", lif.mem_r, 1'b0);
        chk("rst_mem_adr", lif.mem_adr, 64'd0);
        chk("rst_mem_datain", lif.mem_datain, 64'd0);
        run_chk = 1'b1;
        @(posedge clk);
        #1;

        // Preload, then read-merge-write a byte
        do_op(1'b1, 2'b11, 1'b0, 64'h0, 64'h1122334455667788);
        do_op(1'b1, 2'b00, 1'b0, 64'h5, 64'hAB);
        chk("st_b_wdat", last_wdat, 64'h1122AB4455667788);
        chk("st_b_mem", dmem[0], 64'h1122AB4455667788);
        chk("st_b_lat", 64'(last_lat), 64'd3);
        do_op(1'b0, 2'b11, 1'b0, 64'h0, 64'h0);
        chk("ld_d0", last_rdata, 64'h1122AB4455667788);

        // Lane extraction and extension
        do_op(1'b0, 2'b00, 1'b0, 64'h5, 64'h0);
        chk("ld_b_s", last_rdata, 64'hFFFFFFFFFFFFFFAB);
        chk("ld_b_lat", 64'(last_lat), 64'd2);
        chk("ld_b_adr", last_rd_adr, 64'd0);
        do_op(1'b0, 2'b00, 1'b1, 64'h5, 64'h0);
        chk("ld_b_u", last_rdata, 64'h00000000000000AB);
        do_op(1'b0, 2'b01, 1'b0, 64'h6, 64'h0);
        chk("ld_h_s", last_rdata, 64'h0000000000001122);

        // Dword store: one WR, no RD
        r0 = n_rd;
        w0 = n_wr;
        do_op(1'b1, 2'b11, 1'b0, 64'h8, 64'hDEADBEEFCAFEF00D);
        chk("st_d_rd_cnt", 64'(n_rd - r0), 64'd0);
        chk("st_d_wr_cnt", 64'(n_wr - w0), 64'd1);
        do_op(1'b0, 2'b11, 1'b0, 64'h8, 64'h0);
        chk("ld_d8", last_rdata, 64'hDEADBEEFCAFEF00D);

        // Half store then negative half and word loads
        do_op(1'b1, 2'b01, 1'b0, 64'hA, 64'h8001);
        do_op(1'b0, 2'b01, 1'b0, 64'hA, 64'h0);
        chk("ld_h_neg", last_rdata, 64'hFFFFFFFFFFFF8001);
        do_op(1'b0, 2'b10, 1'b1, 64'h8, 64'h0);
        chk("ld_w_u", last_rdata, 64'h000000008001F00D);
        do_op(1'b0, 2'b10, 1'b0, 64'h8, 64'h0);
        chk("ld_w_s", last_rdata, 64'hFFFFFFFF8001F00D);

`ifdef LSU_ALIGN_CHECK_EN
        r0 = n_rd;
        w0 = n_wr;
        do_op(1'b0, 2'b10, 1'b0, 64'h2, 64'h0);
        chk("err_w_rdata", last_rdata, 64'd0);
        chk("err_w_lat", 64'(last_lat), 64'd1);
        do_op(1'b0, 2'b11, 1'b0, 64'h20, 64'h0);
        chk("err_d_rdata", last_rdata, 64'd0);
        chk("err_d_lat", 64'(last_lat), 64'd1);
        chk("err_rd_cnt", 64'(n_rd - r0), 64'd0);
        chk("err_wr_cnt", 64'(n_wr - w0), 64'd0);
`else
        // Word at lane 6 runs past the dword: upper two bytes read as 0
        do_op(1'b0, 2'b10, 1'b0, 64'hE, 64'h0);
        chk("ld_w_trunc", last_rdata, 64'h000000000000DEAD);
`endif

        // Reset during the RD of a byte store aborts it
        saved = dmem[0];
        p0    = n_resp;
        w0    = n_wr;
        free_strobes = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 64'h1, 64'h5A, 1'b0);
        lif.req_valid = 1'b0;
        chk1("abort_in_rd", lif.mem_r, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_mem", dmem[0], 64'h1122AB4455667788);
        chk("abort_mem_saved", dmem[0], saved);
        chk("abort_resp_cnt", 64'(n_resp - p0), 64'd0);
        chk("abort_wr_cnt", 64'(n_wr - w0), 64'd0);
        chk1("abort_ready", lif.req_ready, 1'b1);
        free_strobes = 1'b0;
        @(posedge clk);
        #1;

        // Three back-to-back loads with req_valid held
        resp_cyc.delete();
        resp_dat.delete();
        issue(1'b0, 2'b00, 1'b1, 64'h0, 64'h0, 1'b1);
        issue(1'b0, 2'b01, 1'b1, 64'h2, 64'h0, 1'b1);
        issue(1'b0, 2'b11, 1'b0, 64'h8, 64'h0, 1'b1);
        lif.req_valid = 1'b0;
        drain();
        chk("b2b_count", 64'(resp_cyc.size()), 64'd3);
        if (resp_cyc.size() == 3) begin
            chk("b2b_gap1", 64'(resp_cyc[1] - resp_cyc[0]), 64'd3);
            chk("b2b_gap2", 64'(resp_cyc[2] - resp_cyc[1]), 64'd3);
            chk("b2b_dat0", resp_dat[0], 64'h0000000000000088);
            chk("b2b_dat1", resp_dat[1], 64'h0000000000005566);
            chk("b2b_dat2", resp_dat[2], 64'hDEADBEEF8001F00D);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for the 64-bit byte-addressed data memory. Accepts one load or store per handshake from the pipeline MEM stage and drives the memory's `adr`/`datain`/`w`/`r` ports. Supports byte, half, word and dword accesses: loads extract and extend the addressed lane, and sub-dword stores perform a read-merge-write. The unit is single-outstanding; the MEM stage stalls on `req_ready`.

## Interface
- `MEM_BYTES`, 32: data memory size in bytes; must be a multiple of 8.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 dword.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0. Ignored for stores.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: store data, right-aligned (lane 0 = bits 7:0).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected; qualified by `resp_valid`.
- `mem_adr` out 64: dword-aligned memory address.
- `mem_datain` out 64: write data to memory.
- `mem_w` out 1: memory write enable; the memory writes at the rising edge.
- `mem_r` out 1: memory read enable.
- `mem_dataout` in 64: combinational memory read data; valid only while `mem_r`=1.

## Operation
- **Request latching:** a request is accepted on a rising edge with `req_valid & req_ready`. At that edge the unit latches op, size, unsigned, addr, and wdata.
- **Address split:** `base = addr & ~7`; `lane = addr[2:0]`; `nbytes = 1 << size`. `mem_adr` always equals the latched `base`.
- **States:**
  - IDLE (`req_ready`=1).
  - RD (`mem_r`=1; capture `mem_dataout` into `rbuf` at the exit edge).
  - WR (`mem_w`=1, `mem_datain`=`wbuf`).
  - RESP (`resp_valid`=1).
- **Transitions:**
  - Load: IDLE→RD→RESP→IDLE.
  - Dword store: IDLE→WR→RESP. Here `wbuf = wdata`.
  - Sub-dword store: IDLE→RD→WR→RESP. Here `wbuf` = `rbuf` with bytes `[lane, lane+nbytes-1]` replaced by `wdata[8*nbytes-1:0]`; all other bytes are preserved.
  - Error: IDLE→RESP, with `resp_err`=1 and no memory access.
- **Load extraction:** `(rbuf >> 8*lane)` truncated to `8*nbytes` bits, then sign- or zero-extended to 64 bits per `req_unsigned`. A dword load returns `rbuf` unchanged.
- **Strobe rules:**
  - `mem_r` and `mem_w` are never asserted in the same cycle.
  - Both strobes are decoded from state and latched registers only. There is no combinational path from `req_*` to `mem_*` or to `resp_*`.
- **Idle outputs:** outside WR, `mem_datain`=0. Outside RD/WR, `mem_adr` holds its last value.
- **Reset values:** `req_ready`=1 after reset release. All other outputs are 0: `resp_valid`, `resp_err`, `resp_rdata`, `mem_w`, `mem_r`, `mem_adr`, `mem_datain`. State=IDLE.
- **Reset mid-operation:** the FSM returns to IDLE asynchronously and `mem_w` drops immediately. A reset asserted during RD or WR aborts the access: no partial merge is written and no response is issued.

## Timing
- Latency is counted from the accept edge (cycle 0) to the cycle in which `resp_valid` is high:
  - Load: 2 (RD in cycle 1, RESP in cycle 2).
  - Dword store: 2.
  - Sub-dword store: 3.
  - Error: 1.
- `req_ready` is low from the cycle after accept through RESP. It returns high in the cycle after RESP, so the next accept is possible at the RESP→IDLE edge +1.
- Minimum issue intervals: 3 cycles for loads, 4 for sub-dword stores.
- The store write takes effect at the rising edge that ends WR. A load issued afterwards observes the new data.
- `resp_rdata` and `resp_err` are stable only while `resp_valid`=1.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A request is an error if `addr[2:0]` is not a multiple of `nbytes`, or if `base >= MEM_BYTES`.
  - An error request takes the Error path: `resp_err`=1, `resp_rdata`=0, latency 1, no `mem_r`/`mem_w`.
- `LSU_ALIGN_CHECK_EN` undefined:
  - No checks are performed and `resp_err` is tied to 0.
  - Misaligned lanes are truncated at the dword boundary: bytes beyond lane 7 are dropped on stores and read as 0 before extension on loads.

## Test plan
- Preload dword@0 = 0x1122334455667788, then store byte 0xAB at addr 0x05 → WR cycle drives `mem_datain`=0x1122AB4455667788. Dword@0 reads back 0x1122AB4455667788, and the response arrives 3 cycles after accept.
- Signed byte load at 0x05 → `resp_rdata`=0xFFFFFFFFFFFFFFAB. The unsigned load returns 0x00000000000000AB. `mem_adr`=0 during RD and latency is 2.
- Signed half load at 0x06 → 0x0000000000001122. A dword store of 0xDEADBEEFCAFEF00D at 0x08 gives a single WR cycle with no RD, and a subsequent dword load at 0x08 returns the same value.
- With `LSU_ALIGN_CHECK_EN`, a word load at 0x02 and a dword load at 0x20 each give `resp_err`=1 and `resp_rdata`=0 one cycle after accept. `mem_r` and `mem_w` stay 0 throughout.
- Assert `reset` during the RD cycle of a byte store to 0x01 → `mem_w` is never asserted, dword@0 is unchanged, `resp_valid` stays 0, and `req_ready`=1 after release.
- Hold `req_valid`=1 with three back-to-back loads → `req_ready`=0 while busy. Exactly three `resp_valid` pulses occur, spaced 3 cycles apart, in request order.
